// File: rtl/aud_playback.sv
`default_nettype none
// ==== aud_playback: SRAM sample playback with fast/slow speed control ====
// ==== MSB-first serializer onto the codec DAC line.  rev 1.0         ====
module aud_playback #(
  parameter int SPEED_W = 3,
  parameter int ADDR_W  = 20
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_lrc,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_stop,
  input  logic               i_fast,
  input  logic               i_slow_lin,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic [ADDR_W-1:0]  i_end_addr,
  input  logic [15:0]        i_sram_data,
  output logic [ADDR_W-1:0]  o_sram_addr,
  output logic               o_dac_data,
  output logic               o_playing,
  output logic               o_done
);

  localparam int NW  = SPEED_W + 1;
  localparam int MW  = 16 + NW;
  localparam int AW1 = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CALC  = 3'd2,
    S_WAIT  = 3'd3,
    S_SEND  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [SPEED_W-1:0] k_q, k_d;
  logic [15:0]        prev_q, prev_d;
  logic [15:0]        cur_q, cur_d;
  logic [15:0]        shreg_q, shreg_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic               phase_q, phase_d;
  logic               lrc_dly_q, lrc_dly_d;
  logic               dac_q, dac_d;
  logic               done_q, done_d;
  logic               pause_req_q, pause_req_d;
  logic               fast_q, fast_d;
  logic               lin_q, lin_d;
  logic [SPEED_W-1:0] speed_q, speed_d;

  logic [NW-1:0]        n_w, nk_w, k_inc_w;
  logic                 is_fast_w, is_slow_w;
  logic signed [MW-1:0] num_w;
  logic [15:0]          quo_w, out_w;
  logic [AW1-1:0]       next_addr_w;
  logic [SPEED_W-1:0]   next_k_w;
  logic [15:0]          next_prev_w;

  assign o_sram_addr = addr_q;
  assign o_dac_data  = dac_q;
  assign o_done      = done_q;
  assign o_playing   = (state_q == S_FETCH) || (state_q == S_CALC) ||
                       (state_q == S_WAIT)  || (state_q == S_SEND);

  // Sample arithmetic uses the mode latched at the start of this frame.
  always_comb begin
    n_w       = {1'b0, speed_q} + NW'(1);
    nk_w      = n_w - {1'b0, k_q};
    is_fast_w = fast_q && (speed_q != '0);
    is_slow_w = !fast_q && (speed_q != '0);
    num_w     = $signed({{NW{prev_q[15]}}, prev_q}) * $signed({{16{1'b0}}, nk_w})
              + $signed({{NW{cur_q[15]}}, cur_q}) * $signed({{16{1'b0}}, 1'b0, k_q});
    quo_w     = 16'(num_w / $signed({{16{1'b0}}, n_w}));
    out_w     = (is_slow_w && lin_q) ? quo_w : cur_q;
  end

  always_comb begin
    k_inc_w     = {1'b0, k_q} + NW'(1);
    next_addr_w = {1'b0, addr_q};
    next_k_w    = '0;
    next_prev_w = cur_q;
    if (is_fast_w) begin
      next_addr_w = {1'b0, addr_q} + AW1'(n_w);
    end else if (is_slow_w && (k_inc_w < n_w)) begin
      next_k_w    = k_inc_w[SPEED_W-1:0];
      next_prev_w = prev_q;
    end else begin
      next_addr_w = {1'b0, addr_q} + AW1'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    k_d         = k_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    phase_d     = phase_q;
    lrc_dly_d   = i_lrc;
    dac_d       = dac_q;
    done_d      = 1'b0;
    pause_req_d = pause_req_q;
    fast_d      = fast_q;
    lin_d       = lin_q;
    speed_d     = speed_q;

    if (i_stop) begin
      state_d     = S_IDLE;
      addr_d      = '0;
      k_d         = '0;
      prev_d      = '0;
      dac_d       = 1'b0;
      pause_req_d = 1'b0;
      phase_d     = 1'b0;
      bit_cnt_d   = '0;
    end else begin
      if (i_pause && o_playing) pause_req_d = 1'b1;
      case (state_q)
        S_IDLE: if (i_start) state_d = S_FETCH;
        S_FETCH: begin
          fast_d  = i_fast;
          lin_d   = i_slow_lin;
          speed_d = i_speed;
          // A shorter slow factor than the running frame index restarts the sample.
          if ({1'b0, k_q} >= ({1'b0, i_speed} + NW'(1))) k_d = '0;
          phase_d = 1'b0;
          state_d = S_CALC;
        end
        S_CALC: begin
          if (!phase_q) begin
            cur_d   = i_sram_data;
            phase_d = 1'b1;
          end else begin
            shreg_d = out_w;
            phase_d = 1'b0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (lrc_dly_q && !i_lrc) begin
            dac_d     = shreg_q[15];
            shreg_d   = {shreg_q[14:0], 1'b0};
            bit_cnt_d = '0;
            state_d   = S_SEND;
          end
        end
        S_SEND: begin
          if (bit_cnt_q == 4'd15) begin
            dac_d = 1'b0;
            if (next_addr_w > {1'b0, i_end_addr}) begin
              state_d     = S_IDLE;
              addr_d      = '0;
              k_d         = '0;
              prev_d      = '0;
              done_d      = 1'b1;
              pause_req_d = 1'b0;
            end else begin
              addr_d = next_addr_w[ADDR_W-1:0];
              k_d    = next_k_w;
              prev_d = next_prev_w;
              if (pause_req_q || i_pause) begin
                state_d     = S_PAUSE;
                pause_req_d = 1'b0;
              end else begin
                state_d = S_FETCH;
              end
            end
          end else begin
            dac_d     = shreg_q[15];
            shreg_d   = {shreg_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_PAUSE: if (i_start) state_d = S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      k_q         <= '0;
      prev_q      <= '0;
      cur_q       <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      phase_q     <= 1'b0;
      lrc_dly_q   <= 1'b0;
      dac_q       <= 1'b0;
      done_q      <= 1'b0;
      pause_req_q <= 1'b0;
      fast_q      <= 1'b0;
      lin_q       <= 1'b0;
      speed_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      k_q         <= k_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      phase_q     <= phase_d;
      lrc_dly_q   <= lrc_dly_d;
      dac_q       <= dac_d;
      done_q      <= done_d;
      pause_req_q <= pause_req_d;
      fast_q      <= fast_d;
      lin_q       <= lin_d;
      speed_q     <= speed_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aud_playback.sv
`default_nettype none
// ==== tb_aud_playback: scoreboard bench for aud_playback ====
// ==== rev 1.0                                            ====
module tb_aud_playback;

  localparam int HALF = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lrc = 1'b1;
  logic        start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic        fast = 1'b0, lin = 1'b0;
  logic [2:0]  speed = '0;
  logic [19:0] end_addr = '0;
  logic [15:0] sram_data = '0;
  logic [19:0] sram_addr;
  logic        dac, playing, done;

  logic [15:0] mem [0:63];

  typedef struct {
    logic [15:0] word;
    int          nbits;
  } frame_t;

  frame_t      exp_q[$];
  logic [15:0] ref_q[$];
  int vectors = 0, errors = 0;
  int exp_done = 0, act_done = 0;
  bit capturing = 1'b0;

  aud_playback #(.SPEED_W(3), .ADDR_W(20)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_lrc       (lrc),
    .i_start     (start),
    .i_pause     (pause),
    .i_stop      (stop),
    .i_fast      (fast),
    .i_slow_lin  (lin),
    .i_speed     (speed),
    .i_end_addr  (end_addr),
    .i_sram_data (sram_data),
    .o_sram_addr (sram_addr),
    .o_dac_data  (dac),
    .o_playing   (playing),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sram_data <= mem[sram_addr[5:0]];

  initial forever begin
    repeat (HALF) @(negedge clk);
    lrc = ~lrc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the sequence of left-frame words a whole playback produces.
  function automatic void build(input int last, input bit f, input bit l, input int sp);
    int n, prev, cur, v;
    ref_q.delete();
    n = sp + 1;
    if (n == 1 || f) begin
      for (int a = 0; a <= last; a += n) ref_q.push_back(mem[a]);
    end else begin
      prev = 0;
      for (int a = 0; a <= last; a++) begin
        cur = $signed(mem[a]);
        for (int k = 0; k < n; k++) begin
          v = l ? (prev * (n - k) + cur * k) / n : cur;
          ref_q.push_back(16'(v));
        end
        prev = cur;
      end
    end
  endfunction

  task automatic push_from(input int first);
    for (int i = first; i < ref_q.size(); i++) exp_q.push_back('{ref_q[i], 16});
  endtask

  // Frame monitor: deserializes each left frame and checks it against the queue.
  initial begin : mon
    logic        last_lrc;
    logic [15:0] w, mask;
    int          nb;
    frame_t      e;
    last_lrc = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (last_lrc && !lrc && playing && rst_n) begin
        capturing = 1'b1;
        w  = '0;
        nb = 0;
        for (int i = 15; i >= 0; i--) begin
          if (i != 15) begin @(posedge clk); #1; end
          if (!playing) break;
          w[i] = dac;
          nb++;
        end
        if (nb == 16) begin
          @(posedge clk); #1;
        end
        check("dac_idle_after_frame", {31'b0, dac}, 32'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_frame: got %h (%0d bits) expected no frame", w, nb);
        end else begin
          e    = exp_q.pop_front();
          mask = 16'hFFFF << (16 - e.nbits);
          check("frame_bits", nb, e.nbits);
          check("frame_data", {16'b0, w & mask}, {16'b0, e.word & mask});
        end
        capturing = 1'b0;
      end
      last_lrc = lrc;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (done) begin
      act_done++;
      check("done_addr_zero", sram_addr, 32'd0);
      check("done_idle", {31'b0, playing}, 32'd0);
    end
  end

  task automatic pulse_start();
    @(posedge lrc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic drain();
    int c, budget;
    c = 0;
    budget = 2 * HALF * (exp_q.size() + 3);
    while ((exp_q.size() != 0 || capturing || act_done != exp_done) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("drain_in_budget", {31'b0, c < budget}, 32'd1);
    check("done_count", act_done, exp_done);
    exp_q.delete();
    act_done = exp_done;
  endtask

  task automatic run_play(input int last, input bit f, input bit l, input int sp);
    end_addr = 20'(last);
    fast = f;
    lin = l;
    speed = 3'(sp);
    build(last, f, l, sp);
    push_from(0);
    exp_done++;
    pulse_start();
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (4) @(negedge clk);
    check("rst_addr", sram_addr, 32'd0);
    check("rst_dac", {31'b0, dac}, 32'd0);
    check("rst_playing", {31'b0, playing}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mem[0] = 16'hF2CF; mem[1] = 16'hF64F; mem[2] = 16'h83C1;
    run_play(2, 1'b0, 1'b0, 0);

    for (int i = 0; i < 8; i++) mem[i] = 16'(i);
    run_play(7, 1'b1, 1'b0, 2);

    mem[0] = 16'h0000; mem[1] = 16'h0100;
    run_play(1, 1'b0, 1'b1, 3);

    mem[1] = 16'hFF00;
    run_play(1, 1'b0, 1'b1, 1);

    mem[0] = 16'(($urandom));
    run_play(0, 1'b0, 1'b0, 0);

    // Pause during bit 5 of the first frame, then resume.
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    end_addr = 20'd5; fast = 1'b0; lin = 1'b0; speed = 3'd0;
    build(5, 1'b0, 1'b0, 0);
    push_from(0);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    pulse_start();
    @(negedge lrc);
    repeat (10) @(negedge clk); pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    drain();
    repeat (4 * HALF) @(negedge clk);
    check("paused_playing", {31'b0, playing}, 32'd0);
    check("paused_addr", sram_addr, 32'd1);
    push_from(1);
    exp_done++;
    pulse_start();
    drain();

    // Stop during bit 8 of the first frame.
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    build(5, 1'b0, 1'b0, 0);
    exp_q.push_back('{ref_q[0], 8});
    pulse_start();
    @(negedge lrc);
    repeat (8) @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    drain();
    repeat (4 * HALF) @(negedge clk);
    check("stop_playing", {31'b0, playing}, 32'd0);
    check("stop_addr", sram_addr, 32'd0);
    check("stop_dac", {31'b0, dac}, 32'd0);

    // Simultaneous start and stop in IDLE.
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    repeat (4 * HALF) @(negedge clk);
    check("start_stop_idle", {31'b0, playing}, 32'd0);
    check("start_stop_no_done", act_done, exp_done);

    // Asynchronous reset during bit 3, then replay from address 0.
    end_addr = 20'd3;
    build(3, 1'b0, 1'b0, 0);
    exp_q.push_back('{ref_q[0], 13});
    pulse_start();
    @(negedge lrc);
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dac", {31'b0, dac}, 32'd0);
    check("arst_playing", {31'b0, playing}, 32'd0);
    check("arst_addr", sram_addr, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drain();
    run_play(3, 1'b0, 1'b0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      run_play($urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aud_playback.md
# aud_playback

Playback engine directly downstream of the audio recorder. Reads the 16-bit signed samples that the recorder wrote to SRAM, starting at address 0. Applies speed control: fast-forward by skipping samples, or slow motion by sample-hold or linear interpolation. Serializes each output sample MSB-first onto the codec DAC data line, in the left-channel half of each i_lrc frame.

## Interface
- SPEED_W, 3: width of i_speed; factor N = i_speed + 1 (1..8)
- ADDR_W, 20: SRAM address width, matches recorder o_address
- i_clk  in  1  codec bit clock (BCLK); single clock domain; all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_lrc  in  1  codec DACLRCK; 0 = left half-frame; sampled in i_clk domain
- i_start  in  1  one-cycle pulse: start from IDLE, or resume from PAUSE
- i_pause  in  1  one-cycle pulse: pause at end of current frame
- i_stop  in  1  one-cycle pulse: abort immediately
- i_fast  in  1  1 = fast mode
- i_slow_lin  in  1  slow mode only: 1 = linear interpolation, 0 = sample-hold
- i_speed  in  3  speed factor index
- i_end_addr  in  20  last valid sample address (recorder final o_address)
- i_sram_data  in  16  SRAM read data, valid 1 cycle after o_sram_addr changes
- o_sram_addr  out  20  SRAM read address
- o_dac_data  out  1  serial DAC bit
- o_playing  out  1  1 in FETCH/CALC/WAIT/SEND
- o_done  out  1  one-cycle pulse on natural end of playback

## Operation
- Mode selection:
  - Slow mode: i_fast=0 and N>1.
  - Normal mode: N=1, or i_fast=1 with i_speed=0.
  - Fast mode: i_fast=1 with N>1.
- Mode inputs are latched at each frame start (FETCH entry). Changes mid-frame take effect next frame.
- States and transitions:
  - IDLE: addr=0, k=0, prev=0. i_start → FETCH.
  - FETCH: drive o_sram_addr. Capture i_sram_data into cur on the next cycle → CALC.
  - CALC: compute out_sample, up to 10 cycles (serial divider permitted) → WAIT.
  - WAIT: wait for a falling edge of i_lrc (lrc_d=1, i_lrc=0) → SEND.
  - SEND: shift out 16 bits → advance → FETCH, PAUSE, or IDLE.
  - PAUSE: hold addr, k, prev; o_dac_data=0. i_start → FETCH of the same next address.
- Sample arithmetic (two's complement, 16-bit):
  - Fast and normal: out = cur.
  - Slow, hold: out = cur for all N frames of that sample.
  - Slow, linear: out = (prev*(N-k) + cur*k) / N.
    - Signed 20-bit intermediate; truncate toward zero.
    - k = 0..N-1 is the frame index within the current sample.
    - prev = previously fetched sample; prev=0 for address 0.
- Address advance after SEND:
  - Fast: addr += N.
  - Normal: addr += 1.
  - Slow: k += 1. When k = N: k=0, prev=cur, addr += 1.
- End of data:
  - If the next addr would exceed i_end_addr (including fast-step overshoot): → IDLE, o_done=1 for 1 cycle, addr=0.
  - i_end_addr=0: exactly one sample plays.
- Command priority:
  - i_stop has priority over i_pause and i_start in the same cycle.
  - i_stop in any state: → IDLE next cycle, o_dac_data=0, addr=0, no o_done.
  - i_pause during a frame is registered (pause_req) and honored after SEND completes.
  - i_start while playing is ignored.
  - i_pause in IDLE is ignored.
- Asynchronous reset, any state: IDLE, all outputs 0, pause_req cleared.

## Timing
- Reset values: o_sram_addr=0, o_dac_data=0, o_playing=0, o_done=0.
- i_start pulse → o_playing=1 on the next rising edge; FETCH issues address 0 that same cycle.
- SRAM read latency: exactly 1 cycle; i_sram_data is sampled in the cycle after FETCH.
- Bit serialization:
  - Rising edge where the i_lrc falling edge is detected: o_dac_data = bit 15.
  - Each following rising edge: next bit.
  - Bit 0 is held for 1 cycle, then o_dac_data=0.
- Right half-frame (i_lrc=1): o_dac_data=0; this is the fetch and compute window.
- FETCH+CALC must complete within 12 cycles, so the next left half-frame is never missed with ≥16 BCLK per half-frame.
- If WAIT is entered while i_lrc is already 0, the engine waits for the next falling edge. It never sends a partial frame.
- o_done is asserted in the same cycle the state returns to IDLE.

## Test plan
- Normal playback:
  - Stimulus: SRAM[0..2] = F2CF, F64F, 83C1; i_end_addr=2; i_start.
  - Response: 3 left frames serialize F2CF, F64F, 83C1 MSB-first, starting 1 cycle after each lrc fall. o_done pulses after the third frame; addr returns to 0.
- Fast ×3:
  - Stimulus: SRAM[0..7] = 0..7; i_fast=1, i_speed=2, i_end_addr=7.
  - Response: outputs 0000, 0003, 0006, then done (next addr 9 > 7).
- Slow linear ×4:
  - Stimulus: SRAM[0]=0x0000, SRAM[1]=0x0100; i_speed=3, i_slow_lin=1.
  - Response: sample 1 frames output 0000, 0040, 0080, 00C0.
  - Signed check: prev=0x0000, cur=0xFF00, linear ×2 → 0000, FF80.
- Pause/resume:
  - Stimulus: i_pause during bit 5 of frame 1.
  - Response: frame 1 completes intact; no output frames follow; o_playing=0.
  - Then: i_start resumes with frame 2 data, with no sample skipped or repeated.
- Stop and priority:
  - Stimulus: i_stop during bit 8 of frame 1.
  - Response: o_dac_data=0 from the next cycle; IDLE; no o_done.
  - Simultaneous i_start+i_stop in IDLE: engine stays IDLE.
- Reset mid-frame:
  - Stimulus: assert i_rst_n=0 during bit 3.
  - Response: all outputs 0 immediately (asynchronous).
  - After release: i_start replays from address 0.
